// File: rtl/mitchell_pkg.sv
// Shared widths and the reference antilog for the Mitchell log-domain
// multiplier back end.
//   MITCHELL_W      operand width (A_BW of the upstream pre-approx stages)
//   MITCHELL_KW     width of a leading-one position k
//   MITCHELL_TAG_W  sideband tag width
//   K_SUM_W / E_W   width of k_a+k_b and of the final exponent (max 2W-1)
//   M_W             width of the mantissa {1, s[W-1:0]}
//   P_W / PROD_W    shifter working width and product width
package mitchell_pkg;

    localparam int MITCHELL_W     = 8;
    localparam int MITCHELL_KW    = $clog2(MITCHELL_W);
    localparam int MITCHELL_TAG_W = 4;

    localparam int K_SUM_W = MITCHELL_KW + 1;
    localparam int E_W     = MITCHELL_KW + 1;
    localparam int M_W     = MITCHELL_W + 1;
    localparam int P_W     = 3 * MITCHELL_W;
    localparam int PROD_W  = 2 * MITCHELL_W;

    // Antilog of a Q1.W mantissa scaled by 2^e, floored to an integer.
    function automatic logic [PROD_W-1:0] antilog(input logic [M_W-1:0] m,
                                                  input logic [E_W-1:0] e);
        return PROD_W'((P_W'(m) << e) >> MITCHELL_W);
    endfunction

endpackage

// File: rtl/mitchell_antilog_shift.sv
// Combinational Mitchell antilog: shifts the Q1.W mantissa left by the
// exponent inside a 3W-bit window and keeps the integer part (floor).
// Written without pipeline state so a divider back end can reuse it.
//   m       in  W+1   mantissa {1, fraction}
//   e       in  EW    exponent, at most 2W-1
//   zero    in  1     force the result to 0 (an operand was zero)
//   product out 2W    floor(m * 2^e / 2^W), or 0 when zero=1
module mitchell_antilog_shift #(
    parameter int W  = 8,
    parameter int EW = 4
) (
    input  logic [W:0]     m,
    input  logic [EW-1:0]  e,
    input  logic           zero,
    output logic [2*W-1:0] product
);

    localparam int P_W = 3 * W;

    logic [2*W-1:0] p_int;

    // m < 2^(W+1) and e <= 2W-1, so m<<e always fits in 3W bits; dropping
    // the low W bits after the shift is the truncating fixed-point floor.
    assign p_int   = (2*W)'((P_W'(m) << e) >> W);
    assign product = zero ? '0 : p_int;

endmodule

// File: rtl/mitchell_log_mult_pipe.sv
// Log-domain back end of the Mitchell approximate multiplier.
// Three registered stages:
//   S1  k_sum = k_a+k_b, s = x_a+x_b, z = zero_a|zero_b, tag
//   S2  e = k_sum + s[W], m = {1, s[W-1:0]}, z, tag
//   S3  product = z ? 0 : floor(m * 2^e / 2^W), tag
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready     operand pair handshake
//   k_a,k_b  (KW)         leading-one positions
//   x_a,x_b  (W)          fractions, implicit leading 1 dropped
//   zero_a,zero_b         operand is zero
//   in_tag   (TAG_W)      sideband, returned on out_tag
//   out_valid/out_ready   product handshake
//   product  (2W)         approximate A*B
//   out_tag  (TAG_W)      tag of the same transaction
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds valid and payload until the transfer; ready
// may depend combinationally on the downstream ready. Here stage n loads
// when it is empty or when stage n+1 loads in the same cycle, so bubbles
// collapse and a full pipe still moves one item per cycle while out_ready=1.
module mitchell_log_mult_pipe
    import mitchell_pkg::*;
#(
    parameter int W     = MITCHELL_W,
    parameter int KW    = $clog2(W),
    parameter int TAG_W = MITCHELL_TAG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [KW-1:0]    k_a,
    input  logic [KW-1:0]    k_b,
    input  logic [W-1:0]     x_a,
    input  logic [W-1:0]     x_b,
    input  logic             zero_a,
    input  logic             zero_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   product,
    output logic [TAG_W-1:0] out_tag
);

    localparam int KS_W = KW + 1;

    logic v1, v2, v3;
    logic load1, load2, load3;

    // S1 registers
    logic [KS_W-1:0]  k_sum1;
    logic [W:0]       s1;
    logic             z1;
    logic [TAG_W-1:0] tag1;

    // S2 registers
    logic [KS_W-1:0]  e2;
    logic [W:0]       m2;
    logic             z2;
    logic [TAG_W-1:0] tag2;

    // S3 registers
    logic [2*W-1:0]   prod3;
    logic [TAG_W-1:0] tag3;

    logic [2*W-1:0]   prod_next;

    // Ready chain, output side first.
    assign load3    = ~v3 | out_ready;
    assign load2    = ~v2 | load3;
    assign load1    = ~v1 | load2;
    assign in_ready = load1;

    // Stage 1: log-domain addition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1     <= 1'b0;
            k_sum1 <= '0;
            s1     <= '0;
            z1     <= 1'b0;
            tag1   <= '0;
        end else if (load1) begin
            v1 <= in_valid;
            if (in_valid) begin
                k_sum1 <= {1'b0, k_a} + {1'b0, k_b};
                s1     <= {1'b0, x_a} + {1'b0, x_b};
                z1     <= zero_a | zero_b;
                tag1   <= in_tag;
            end
        end
    end

    // Stage 2: fold the fraction carry into the exponent. With carry the
    // value is 2^(k+1)*s (s already carries the 1); without it, 2^k*(1+s).
    // Both reduce to {1, s[W-1:0]} << (k_sum + carry).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2   <= 1'b0;
            e2   <= '0;
            m2   <= '0;
            z2   <= 1'b0;
            tag2 <= '0;
        end else if (load2) begin
            v2 <= v1;
            if (v1) begin
                e2   <= k_sum1 + KS_W'(s1[W]);
                m2   <= {1'b1, s1[W-1:0]};
                z2   <= z1;
                tag2 <= tag1;
            end
        end
    end

    mitchell_antilog_shift #(
        .W  (W),
        .EW (KS_W)
    ) u_shift (
        .m       (m2),
        .e       (e2),
        .zero    (z2),
        .product (prod_next)
    );

    // Stage 3: registered antilog result; holds while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3    <= 1'b0;
            prod3 <= '0;
            tag3  <= '0;
        end else if (load3) begin
            v3 <= v2;
            if (v2) begin
                prod3 <= prod_next;
                tag3  <= tag2;
            end
        end
    end

    assign out_valid = v3;
    assign product   = prod3;
    assign out_tag   = tag3;

endmodule
